dfdd_frame_sink: RTL and testbench

- Receiving end of the dual-scale depth pipeline's output stream: consumes the per-pixel fp16 depth/confidence stream (z, c, col, row, valid) and turns it into framed, back-pressurable output words.
- Checks raster order against the configured image size and masks low-confidence depth.
- Buffers pixels in a FIFO so a stallable downstream consumer (frame writer / host link) can be attached to the non-stallable datapath.

---
 rtl/dfdd_frame_sink_if.sv | 22 ++
 rtl/dfdd_frame_sink.sv | 183 ++++++++++++++++++
 tb/tb_dfdd_frame_sink.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dfdd_frame_sink_if.sv
// rtl/dfdd_frame_sink_if.sv - framed output stream of the depth frame sink
interface dfdd_frame_sink_if #(
   parameter int FP_W = 16
);
   logic [2*FP_W-1:0] m_data_o;
   logic              m_mask_o;
   logic              m_sof_o;
   logic              m_eol_o;
   logic              m_eof_o;
   logic              m_valid_o;
   logic              m_ready_i;

   modport master (
      output m_data_o, m_mask_o, m_sof_o, m_eol_o, m_eof_o, m_valid_o,
      input  m_ready_i
   );

   modport slave (
      input  m_data_o, m_mask_o, m_sof_o, m_eol_o, m_eof_o, m_valid_o,
      output m_ready_i
   );
endinterface

// File: rtl/dfdd_frame_sink.sv
// rtl/dfdd_frame_sink.sv - raster-checked, confidence-masked depth stream into a FWFT FIFO
module dfdd_frame_sink #(
   parameter int IMAGE_WIDTH  = 50,
   parameter int IMAGE_HEIGHT = 50,
   parameter int EXP_WIDTH    = 5,
   parameter int FRAC_WIDTH   = 10,
   parameter int FIFO_DEPTH   = 16,
   localparam int FP_W        = 1 + EXP_WIDTH + FRAC_WIDTH
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [FP_W-1:0]      z_i,
   input  logic [FP_W-1:0]      c_i,
   input  logic [15:0]          col_i,
   input  logic [15:0]          row_i,
   input  logic                 valid_i,
   input  logic [FP_W-1:0]      c_threshold_i,
   input  logic                 clear_i,
   dfdd_frame_sink_if.master    m,
   output logic                 overflow_o,
   output logic                 seq_error_o,
   output logic [15:0]          frame_count_o
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = 2 * FP_W + 4;
   localparam logic [15:0] LAST_COL = 16'(IMAGE_WIDTH - 1);
   localparam logic [15:0] LAST_ROW = 16'(IMAGE_HEIGHT - 1);

   typedef enum logic [0:0] {SEEK_SOF, IN_FRAME} state_t;

   state_t        state_q, state_d;
   logic [15:0]   exp_col_q, exp_col_d;
   logic [15:0]   exp_row_q, exp_row_d;

   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;

   logic          is_origin, is_match, pix_eol, pix_eof, mask;
   logic          pop, full, can_push;
   logic          accept, sof, push, eof_push, seq_set, ovf_set;
   logic [FP_W-1:0] z_masked;
   logic [EW-1:0] entry, head;
   logic          out_valid;

   assign is_origin = (col_i == 16'd0) && (row_i == 16'd0);
   assign is_match  = (col_i == exp_col_q) && (row_i == exp_row_q);
   assign pix_eol   = (col_i == LAST_COL);
   assign pix_eof   = pix_eol && (row_i == LAST_ROW);
   // Sign bit forces a mask; otherwise magnitudes compare as unsigned integers.
   assign mask      = c_i[FP_W-1] || (c_i[FP_W-2:0] < c_threshold_i[FP_W-2:0]);
   assign z_masked  = mask ? '0 : z_i;
   assign entry     = {z_masked, c_i, mask, sof, pix_eol, pix_eof};

   assign out_valid = (count != '0);
   assign pop       = out_valid && m.m_ready_i;
   assign full      = (count == CW'(FIFO_DEPTH));
   assign can_push  = !full || pop;

   always_comb begin
      state_d   = state_q;
      exp_col_d = exp_col_q;
      exp_row_d = exp_row_q;
      accept    = 1'b0;
      sof       = 1'b0;
      seq_set   = 1'b0;
      ovf_set   = 1'b0;
      push      = 1'b0;
      eof_push  = 1'b0;

      if (valid_i) begin
         case (state_q)
            SEEK_SOF: begin
               if (is_origin) begin
                  accept = 1'b1;
                  sof    = 1'b1;
               end
            end
            IN_FRAME: begin
               if (is_match) begin
                  accept = 1'b1;
               end else begin
                  seq_set = 1'b1;
                  if (is_origin) begin
                     accept = 1'b1;
                     sof    = 1'b1;
                  end else begin
                     state_d = SEEK_SOF;
                  end
               end
            end
            default: state_d = SEEK_SOF;
         endcase
      end

      if (accept) begin
         if (can_push) begin
            push = 1'b1;
            if (pix_eof) begin
               eof_push = 1'b1;
               state_d  = SEEK_SOF;
            end else begin
               state_d = IN_FRAME;
            end
            if (pix_eol) begin
               exp_col_d = 16'd0;
               exp_row_d = row_i + 16'd1;
            end else begin
               exp_col_d = col_i + 16'd1;
               exp_row_d = row_i;
            end
         end else begin
            // No room: abandon the frame rather than emit a hole in it.
            ovf_set = 1'b1;
            state_d = SEEK_SOF;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= SEEK_SOF;
         exp_col_q <= 16'd0;
         exp_row_q <= 16'd0;
      end else begin
         state_q   <= state_d;
         exp_col_q <= exp_col_d;
         exp_row_q <= exp_row_d;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         overflow_o    <= 1'b0;
         seq_error_o   <= 1'b0;
         frame_count_o <= 16'd0;
      end else begin
         overflow_o  <= ovf_set || (overflow_o && !clear_i);
         seq_error_o <= seq_set || (seq_error_o && !clear_i);
         if (clear_i) begin
            frame_count_o <= eof_push ? 16'd1 : 16'd0;
         end else if (eof_push) begin
            frame_count_o <= frame_count_o + 16'd1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr] <= entry;
      end
   end

   // Storage is not reset, so fields are gated to zero whenever the FIFO is empty.
   assign head        = out_valid ? mem[rd_ptr] : '0;
   assign m.m_data_o  = head[EW-1:4];
   assign m.m_mask_o  = head[3];
   assign m.m_sof_o   = head[2];
   assign m.m_eol_o   = head[1];
   assign m.m_eof_o   = head[0];
   assign m.m_valid_o = out_valid;
endmodule

// File: tb/tb_dfdd_frame_sink.sv
// tb/tb_dfdd_frame_sink.sv - scoreboard bench for dfdd_frame_sink on a 4x3 image
module tb_dfdd_frame_sink;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] z = '0, c = '0, col = '0, row = '0;
   logic [15:0] thr = 16'h3800;
   logic        valid_a = 1'b0, valid_b = 1'b0, clear = 1'b0;
   logic        ovf_a, ovf_b, seq_a, seq_b;
   logic [15:0] fc_a, fc_b;

   int          checks = 0;
   int          failures = 0;
   logic [35:0] exp_q[$];
   logic [35:0] mon_got, mon_exp;

   dfdd_frame_sink_if #(.FP_W(16)) ifa ();
   dfdd_frame_sink_if #(.FP_W(16)) ifb ();

   dfdd_frame_sink #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(3), .FIFO_DEPTH(16)) dut_a (
      .clk_i(clk), .rst_i(rst), .z_i(z), .c_i(c), .col_i(col), .row_i(row),
      .valid_i(valid_a), .c_threshold_i(thr), .clear_i(clear), .m(ifa.master),
      .overflow_o(ovf_a), .seq_error_o(seq_a), .frame_count_o(fc_a)
   );

   dfdd_frame_sink #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(3), .FIFO_DEPTH(4)) dut_b (
      .clk_i(clk), .rst_i(rst), .z_i(z), .c_i(c), .col_i(col), .row_i(row),
      .valid_i(valid_b), .c_threshold_i(thr), .clear_i(clear), .m(ifb.master),
      .overflow_o(ovf_b), .seq_error_o(seq_b), .frame_count_o(fc_b)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst && ifa.m_valid_o && ifa.m_ready_i) begin
         mon_got = {ifa.m_data_o, ifa.m_mask_o, ifa.m_sof_o, ifa.m_eol_o, ifa.m_eof_o};
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected_word got=%h required=none", mon_got);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_got !== mon_exp) begin
               failures++;
               $display("FAIL sb_word got=%h required=%h", mon_got, mon_exp);
            end
         end
      end
   end

   task automatic drive_pix(input bit to_a, input bit to_b, input logic [15:0] pc,
                            input logic [15:0] pr, input logic [15:0] pz,
                            input logic [15:0] pcc, input bit clr);
      @(posedge clk);
      #1;
      col = pc; row = pr; z = pz; c = pcc;
      valid_a = to_a; valid_b = to_b; clear = clr;
   endtask

   task automatic drive_idle();
      @(posedge clk);
      #1;
      valid_a = 1'b0; valid_b = 1'b0; clear = 1'b0;
   endtask

   task automatic pulse_clear();
      @(posedge clk);
      #1 clear = 1'b1;
      @(posedge clk);
      #1 clear = 1'b0;
   endtask

   task automatic push_exp(input logic [15:0] pz, input logic [15:0] pcc, input bit m,
                           input bit s, input bit el, input bit ef);
      exp_q.push_back({m ? 16'h0000 : pz, pcc, m, s, el, ef});
   endtask

   task automatic wait_drain(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(posedge clk);
         #2;
         if (exp_q.size() == 0) ok = 1'b1;
      end
      repeat (3) @(posedge clk);
      #2;
   endtask

   task automatic send_frame(input logic [15:0] zb, input bit clr_last);
      for (int r = 0; r < 3; r++) begin
         for (int cc = 0; cc < 4; cc++) begin
            int  idx  = r * 4 + cc;
            bit  last = (r == 2) && (cc == 3);
            push_exp(zb + 16'(idx), 16'h3C00, 1'b0, idx == 0, cc == 3, last);
            drive_pix(1'b1, 1'b0, 16'(cc), 16'(r), zb + 16'(idx), 16'h3C00, clr_last && last);
         end
      end
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({ifa.m_valid_o, ifa.m_data_o, ovf_a, seq_a, fc_a} !== 51'd0) begin
         failures++;
         $display("FAIL reset_outputs_a got=%h required=0",
                  {ifa.m_valid_o, ifa.m_data_o, ovf_a, seq_a, fc_a});
      end
      checks++;
      if ({ifb.m_valid_o, ifb.m_data_o, ovf_b, seq_b, fc_b} !== 51'd0) begin
         failures++;
         $display("FAIL reset_outputs_b got=%h required=0",
                  {ifb.m_valid_o, ifb.m_data_o, ovf_b, seq_b, fc_b});
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_full_frame();
      bit ok;
      pulse_clear();
      send_frame(16'h4100, 1'b0);
      drive_idle();
      wait_drain(ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL full_drain got=timeout required=drained"); end
      checks++;
      if ({fc_a, seq_a, ovf_a} !== {16'd1, 2'b00}) begin
         failures++;
         $display("FAIL full_status got=fc%0d seq%0d ovf%0d required=fc1 seq0 ovf0", fc_a, seq_a, ovf_a);
      end
   endtask

   task automatic test_mask();
      bit ok;
      pulse_clear();
      for (int i = 0; i < 12; i++) begin
         logic [15:0] cv = 16'h3C00;
         bit          m  = 1'b0;
         if (i == 1) cv = 16'h3800;
         if (i == 6) begin cv = 16'h3400; m = 1'b1; end
         if (i == 7) begin cv = 16'hBC00; m = 1'b1; end
         push_exp(16'h5200 + 16'(i), cv, m, i == 0, (i % 4) == 3, i == 11);
         drive_pix(1'b1, 1'b0, 16'(i % 4), 16'(i / 4), 16'h5200 + 16'(i), cv, 1'b0);
      end
      drive_idle();
      wait_drain(ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL mask_drain got=timeout required=drained"); end
      checks++;
      if (fc_a !== 16'd1) begin failures++; $display("FAIL mask_fc got=%0d required=1", fc_a); end
   endtask

   task automatic test_seek();
      bit ok;
      pulse_clear();
      drive_pix(1'b1, 1'b0, 16'd2, 16'd0, 16'h6002, 16'h3C00, 1'b0);
      drive_pix(1'b1, 1'b0, 16'd3, 16'd0, 16'h6003, 16'h3C00, 1'b0);
      send_frame(16'h6100, 1'b0);
      drive_idle();
      wait_drain(ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL seek_drain got=timeout required=drained"); end
      checks++;
      if ({seq_a, fc_a} !== {1'b0, 16'd1}) begin
         failures++;
         $display("FAIL seek_status got=seq%0d fc%0d required=seq0 fc1", seq_a, fc_a);
      end
   endtask

   task automatic test_seq_error();
      bit ok;
      pulse_clear();
      for (int i = 0; i < 4; i++) begin
         push_exp(16'h7000 + 16'(i), 16'h3C00, 1'b0, i == 0, i == 3, 1'b0);
         drive_pix(1'b1, 1'b0, 16'(i), 16'd0, 16'h7000 + 16'(i), 16'h3C00, 1'b0);
      end
      drive_pix(1'b1, 1'b0, 16'd1, 16'd1, 16'h7005, 16'h3C00, 1'b0);
      drive_idle();
      #2;
      checks++;
      if ({seq_a, fc_a} !== {1'b1, 16'd0}) begin
         failures++;
         $display("FAIL seq_flag got=seq%0d fc%0d required=seq1 fc0", seq_a, fc_a);
      end
      push_exp(16'h7100, 16'h3C00, 1'b0, 1'b1, 1'b0, 1'b0);
      drive_pix(1'b1, 1'b0, 16'd0, 16'd0, 16'h7100, 16'h3C00, 1'b0);
      push_exp(16'h7101, 16'h3C00, 1'b0, 1'b0, 1'b0, 1'b0);
      drive_pix(1'b1, 1'b0, 16'd1, 16'd0, 16'h7101, 16'h3C00, 1'b0);
      // Premature (0,0) restarts the frame as a fresh sof.
      push_exp(16'h7200, 16'h3C00, 1'b0, 1'b1, 1'b0, 1'b0);
      drive_pix(1'b1, 1'b0, 16'd0, 16'd0, 16'h7200, 16'h3C00, 1'b0);
      for (int i = 1; i < 12; i++) begin
         push_exp(16'h7200 + 16'(i), 16'h3C00, 1'b0, 1'b0, (i % 4) == 3, i == 11);
         drive_pix(1'b1, 1'b0, 16'(i % 4), 16'(i / 4), 16'h7200 + 16'(i), 16'h3C00, 1'b0);
      end
      drive_idle();
      wait_drain(ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL seq_drain got=timeout required=drained"); end
      checks++;
      if ({seq_a, fc_a} !== {1'b1, 16'd1}) begin
         failures++;
         $display("FAIL seq_status got=seq%0d fc%0d required=seq1 fc1", seq_a, fc_a);
      end
   endtask

   task automatic test_clear_collision();
      bit ok;
      send_frame(16'h7800, 1'b1);
      drive_idle();
      wait_drain(ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL clrcol_drain got=timeout required=drained"); end
      checks++;
      if ({seq_a, fc_a} !== {1'b0, 16'd1}) begin
         failures++;
         $display("FAIL clrcol_status got=seq%0d fc%0d required=seq0 fc1", seq_a, fc_a);
      end
   endtask

   task automatic test_overflow();
      logic [35:0] exp_b [4];
      logic [35:0] got;
      int          n = 0;
      ifb.m_ready_i = 1'b0;
      pulse_clear();
      for (int i = 0; i < 12; i++) begin
         if (i < 4) exp_b[i] = {16'h8000 + 16'(i), 16'h3C00, 1'b0, i == 0, i == 3, 1'b0};
         drive_pix(1'b0, 1'b1, 16'(i % 4), 16'(i / 4), 16'h8000 + 16'(i), 16'h3C00, 1'b0);
      end
      drive_idle();
      repeat (2) @(negedge clk);
      got = {ifb.m_data_o, ifb.m_mask_o, ifb.m_sof_o, ifb.m_eol_o, ifb.m_eof_o};
      checks++;
      if (!ifb.m_valid_o || got !== exp_b[0]) begin
         failures++;
         $display("FAIL ovf_head_hold got=v%0d %h required=v1 %h", ifb.m_valid_o, got, exp_b[0]);
      end
      checks++;
      if ({ovf_b, seq_b, fc_b} !== {2'b10, 16'd0}) begin
         failures++;
         $display("FAIL ovf_status got=ovf%0d seq%0d fc%0d required=ovf1 seq0 fc0", ovf_b, seq_b, fc_b);
      end
      @(posedge clk);
      #1 ifb.m_ready_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (ifb.m_valid_o) begin
            got = {ifb.m_data_o, ifb.m_mask_o, ifb.m_sof_o, ifb.m_eol_o, ifb.m_eof_o};
            checks++;
            if (n >= 4 || got !== exp_b[n % 4]) begin
               failures++;
               $display("FAIL ovf_word%0d got=%h required=%h", n, got, exp_b[n % 4]);
            end
            n++;
         end
      end
      checks++;
      if (n != 4) begin failures++; $display("FAIL ovf_word_count got=%0d required=4", n); end
      pulse_clear();
      #1;
      checks++;
      if (ovf_b !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%0d required=0", ovf_b); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      ifa.m_ready_i = 1'b0;
      pulse_clear();
      for (int i = 0; i < 3; i++) begin
         push_exp(16'h9000 + 16'(i), 16'h3C00, 1'b0, i == 0, 1'b0, 1'b0);
         drive_pix(1'b1, 1'b0, 16'(i), 16'd0, 16'h9000 + 16'(i), 16'h3C00, 1'b0);
      end
      drive_idle();
      @(negedge clk);
      checks++;
      if (ifa.m_valid_o !== 1'b1) begin
         failures++;
         $display("FAIL rstmid_buffered got=%0d required=1", ifa.m_valid_o);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({ifa.m_valid_o, ifa.m_data_o} !== 33'd0) begin
         failures++;
         $display("FAIL rstmid_async_drop got=%h required=0", {ifa.m_valid_o, ifa.m_data_o});
      end
      exp_q.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      ifa.m_ready_i = 1'b1;
      send_frame(16'h9100, 1'b0);
      drive_idle();
      wait_drain(ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL rstmid_drain got=timeout required=drained"); end
      checks++;
      if (fc_a !== 16'd1) begin failures++; $display("FAIL rstmid_fc got=%0d required=1", fc_a); end
   endtask

   initial begin
      ifa.m_ready_i = 1'b1;
      ifb.m_ready_i = 1'b1;
      test_reset();
      test_full_frame();
      test_mask();
      test_seek();
      test_seq_error();
      test_clear_collision();
      test_overflow();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
